// File: rtl/vx_cache_mem_pkg.sv
// ---------------------------------------------------------------------------
// vx_cache_mem_pkg
// Shared types and geometry for the cache-bank memory responder.
//   LINE_SIZE  : line size in bytes (data width = 8*LINE_SIZE)
//   ADDR_WIDTH : line-address width (RAM depth = 2**ADDR_WIDTH lines)
//   TAG_WIDTH  : request/response id width (MSHR id of the initiator)
//   mem_req_t  : {rw, addr, byteen, data, tag} as presented by the bank
//   mem_rsp_t  : {data, tag} as returned to the bank (tag drives fill_id)
// ---------------------------------------------------------------------------
package vx_cache_mem_pkg;

    localparam int LINE_SIZE  = 16;
    localparam int ADDR_WIDTH = 8;
    localparam int TAG_WIDTH  = 2;
    localparam int LINE_WIDTH = 8 * LINE_SIZE;

    typedef struct packed {
        logic                  rw;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LINE_SIZE-1:0]  byteen;
        logic [LINE_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]  tag;
    } mem_req_t;

    typedef struct packed {
        logic [LINE_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]  tag;
    } mem_rsp_t;

endpackage

// File: rtl/vx_cache_mem_responder_if.sv
// ---------------------------------------------------------------------------
// vx_cache_mem_responder_if
// Line-fill request/response bus between a cache bank (master) and the
// memory responder (slave).
//   request  : mem_req_valid/rw/addr/byteen/data/tag -> , <- mem_req_ready
//   response : <- mem_rsp_valid/data/tag , mem_rsp_ready ->
// Handshake: a beat transfers on a rising clock edge where valid && ready.
// The sender holds valid and payload stable until that edge; ready may
// depend combinationally on the payload (mem_req_rw) but never on valid.
// ---------------------------------------------------------------------------
interface vx_cache_mem_responder_if;
    import vx_cache_mem_pkg::*;

    logic                  mem_req_valid;
    logic                  mem_req_rw;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [LINE_SIZE-1:0]  mem_req_byteen;
    logic [LINE_WIDTH-1:0] mem_req_data;
    logic [TAG_WIDTH-1:0]  mem_req_tag;
    logic                  mem_req_ready;

    logic                  mem_rsp_valid;
    logic [LINE_WIDTH-1:0] mem_rsp_data;
    logic [TAG_WIDTH-1:0]  mem_rsp_tag;
    logic                  mem_rsp_ready;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen,
               mem_req_data, mem_req_tag, mem_rsp_ready,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_byteen,
               mem_req_data, mem_req_tag, mem_rsp_ready,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
    );

endinterface

// File: rtl/vx_cache_mem_rsp_queue.sv
// ---------------------------------------------------------------------------
// vx_cache_mem_rsp_queue
// In-order circular buffer of pending read responses. Each entry carries
// {data, tag} plus a countdown that models the memory latency; the head is
// only offered once its countdown has reached zero.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   push, push_entry  capture a new read (caller guarantees !full)
//   pop_ready         consumer ready for the head entry
//   head_valid        head present and its latency expired
//   head_entry        head {data, tag}, stable while not popped
//   full              MAX_PENDING entries outstanding
//   busy              at least one entry outstanding
// ---------------------------------------------------------------------------
module vx_cache_mem_rsp_queue
    import vx_cache_mem_pkg::*;
#(
    parameter int LATENCY     = 4,
    parameter int MAX_PENDING = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  mem_rsp_t push_entry,
    input  logic     pop_ready,
    output logic     head_valid,
    output mem_rsp_t head_entry,
    output logic     full,
    output logic     busy
);

    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CD_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CD_W-1:0]  CD_INIT  = CD_W'(LATENCY - 1);
    localparam logic [PTR_W:0]   CAPACITY = (PTR_W + 1)'(MAX_PENDING);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             pop;

    mem_rsp_t         entries   [MAX_PENDING];
    logic [CD_W-1:0]  countdown [MAX_PENDING];

    assign head_valid = (count != '0) && (countdown[rd_ptr] == '0);
    assign head_entry = entries[rd_ptr];
    assign pop        = head_valid && pop_ready;
    // No pop bypass: a full queue stays full for the whole cycle.
    assign full       = !(count < CAPACITY);
    assign busy       = (count != '0);

    // Pointers wrap naturally because MAX_PENDING is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Payload and countdowns need no reset: an empty queue ignores them and
    // every push rewrites both. Countdowns tick every cycle and stick at 0.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_PENDING; i++) begin
            if (push && (wr_ptr == PTR_W'(i))) begin
                entries[i]   <= push_entry;
                countdown[i] <= CD_INIT;
            end else if (countdown[i] != '0) begin
                countdown[i] <= countdown[i] - 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_cache_mem_responder.sv
// ---------------------------------------------------------------------------
// vx_cache_mem_responder
// Memory-side responder for a cache bank's line-fill interface. Writes
// update a byte-enabled line RAM; reads snapshot the line at the accept edge
// and return it with the request tag LATENCY cycles later, in order.
// Ports:
//   clk     clock
//   reset   asynchronous active-high reset (drops all outstanding reads;
//           RAM contents survive)
//   mem_if  slave side of the line-fill request/response bus
//   busy    a read is outstanding or a response is being held
// Line geometry (LINE_SIZE, ADDR_WIDTH, TAG_WIDTH) comes from
// vx_cache_mem_pkg.
// ---------------------------------------------------------------------------
module vx_cache_mem_responder
    import vx_cache_mem_pkg::*;
#(
    parameter int LATENCY     = 4,
    parameter int MAX_PENDING = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    vx_cache_mem_responder_if.slave   mem_if,
    output logic                      busy
);

    mem_req_t req;
    mem_rsp_t read_entry;
    mem_rsp_t head_entry;
    logic     queue_full;
    logic     head_valid;
    logic     read_fire;
    logic     write_fire;

    logic [LINE_WIDTH-1:0] ram [2**ADDR_WIDTH];

    assign req = '{
        rw:     mem_if.mem_req_rw,
        addr:   mem_if.mem_req_addr,
        byteen: mem_if.mem_req_byteen,
        data:   mem_if.mem_req_data,
        tag:    mem_if.mem_req_tag
    };

    // Writes never occupy a queue slot, so only reads are throttled by it.
    assign mem_if.mem_req_ready = !reset && (req.rw || !queue_full);

    assign write_fire = mem_if.mem_req_valid && mem_if.mem_req_ready && req.rw;
    assign read_fire  = mem_if.mem_req_valid && mem_if.mem_req_ready && !req.rw;

    always_ff @(posedge clk) begin
        if (write_fire) begin
            for (int b = 0; b < LINE_SIZE; b++) begin
                if (req.byteen[b]) begin
                    ram[req.addr][8*b +: 8] <= req.data[8*b +: 8];
                end
            end
        end
    end

    // The line is captured into the queue at the accept edge, so later
    // writes to the same address cannot alter an already-accepted read.
    assign read_entry = '{data: ram[req.addr], tag: req.tag};

    vx_cache_mem_rsp_queue #(
        .LATENCY     (LATENCY),
        .MAX_PENDING (MAX_PENDING)
    ) rsp_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (read_fire),
        .push_entry (read_entry),
        .pop_ready  (mem_if.mem_rsp_ready),
        .head_valid (head_valid),
        .head_entry (head_entry),
        .full       (queue_full),
        .busy       (busy)
    );

    assign mem_if.mem_rsp_valid = head_valid;
    assign mem_if.mem_rsp_data  = head_entry.data;
    assign mem_if.mem_rsp_tag   = head_entry.tag;

endmodule

// File: tb/tb_vx_cache_mem_responder.sv
module tb_vx_cache_mem_responder;
    import vx_cache_mem_pkg::*;

    localparam int LATENCY     = 4;
    localparam int MAX_PENDING = 4;
    localparam int W           = TAG_WIDTH + LINE_WIDTH;
    localparam int NV          = 12;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    vx_cache_mem_responder_if mem_if();

    vx_cache_mem_responder #(
        .LATENCY     (LATENCY),
        .MAX_PENDING (MAX_PENDING)
    ) dut (
        .clk    (clk),
        .reset  (rst),
        .mem_if (mem_if.slave),
        .busy   (busy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic                  rw;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LINE_SIZE-1:0]  byteen;
        logic [LINE_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]  tag;
        logic [LINE_WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs[NV];

    function automatic logic [LINE_WIDTH-1:0] pat(input logic [7:0] a);
        return {LINE_SIZE{a ^ 8'h3C}};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare the currently offered response against the oldest expectation.
    task automatic check_head(input string name);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: got unexpected response tag %0d data %h expected none",
                     name, mem_if.mem_rsp_tag, mem_if.mem_rsp_data);
        end else begin
            check(name, {mem_if.mem_rsp_tag, mem_if.mem_rsp_data}, exp_q.pop_front());
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 right after the fire edge.
    task automatic send(input logic rw, input logic [ADDR_WIDTH-1:0] addr,
                        input logic [LINE_SIZE-1:0] byteen, input logic [LINE_WIDTH-1:0] data,
                        input logic [TAG_WIDTH-1:0] tag, input logic [LINE_WIDTH-1:0] exp_data);
        bit fired;
        fired = 1'b0;
        mem_if.mem_req_valid  = 1'b1;
        mem_if.mem_req_rw     = rw;
        mem_if.mem_req_addr   = addr;
        mem_if.mem_req_byteen = byteen;
        mem_if.mem_req_data   = data;
        mem_if.mem_req_tag    = tag;
        for (int i = 0; i < 200 && !fired; i++) begin
            @(negedge clk);
            if (mem_if.mem_req_ready) fired = 1'b1;
        end
        if (fired) begin
            @(posedge clk);
            if (!rw) exp_q.push_back({tag, exp_data});
            #1;
        end
        check("req_accept", W'(fired), W'(1));
        mem_if.mem_req_valid = 1'b0;
    endtask

    // Wait (bounded) for a response handshake with rsp_ready held by caller.
    task automatic wait_rsp(input string name, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        for (int i = 1; i <= 50 && !got; i++) begin
            @(negedge clk);
            if (mem_if.mem_rsp_valid && mem_if.mem_rsp_ready) begin
                got = 1'b1;
                lat = i;
                check_head(name);
            end
        end
        check({name, "_seen"}, W'(got), W'(1));
        @(posedge clk);
        #1;
    endtask

    // ---------------- test ----------------
    initial begin
        int lat;
        int stale;

        vecs[0]  = '{1'b1, 8'h10, 16'hFFFF, {16{8'hA5}}, 2'd0, '0};
        vecs[1]  = '{1'b0, 8'h10, 16'h0000, '0, 2'd2, {16{8'hA5}}};
        vecs[2]  = '{1'b1, 8'h30, 16'hFFFF, '0, 2'd0, '0};
        vecs[3]  = '{1'b1, 8'h30, 16'h0001, {16{8'hFF}}, 2'd0, '0};
        vecs[4]  = '{1'b0, 8'h30, 16'h0000, '0, 2'd1, 128'hFF};
        vecs[5]  = '{1'b1, 8'h31, 16'hFFFF, 128'h0123456789ABCDEF_FEDCBA9876543210, 2'd0, '0};
        vecs[6]  = '{1'b1, 8'h31, 16'hFF00, {16{8'h77}}, 2'd0, '0};
        vecs[7]  = '{1'b0, 8'h31, 16'h0000, '0, 2'd3, 128'h7777777777777777_FEDCBA9876543210};
        vecs[8]  = '{1'b1, 8'hFF, 16'hFFFF, {4{32'hDEADBEEF}}, 2'd0, '0};
        vecs[9]  = '{1'b0, 8'hFF, 16'h0000, '0, 2'd0, {4{32'hDEADBEEF}}};
        vecs[10] = '{1'b1, 8'h00, 16'hFFFF, 128'h1, 2'd0, '0};
        vecs[11] = '{1'b0, 8'h00, 16'h0000, '0, 2'd1, 128'h1};

        rst                   = 1'b1;
        mem_if.mem_req_valid  = 1'b0;
        mem_if.mem_req_rw     = 1'b0;
        mem_if.mem_req_addr   = '0;
        mem_if.mem_req_byteen = '0;
        mem_if.mem_req_data   = '0;
        mem_if.mem_req_tag    = '0;
        mem_if.mem_rsp_ready  = 1'b1;

        // reset state
        #2;
        check("rst_req_ready", W'(mem_if.mem_req_ready), W'(0));
        check("rst_rsp_valid", W'(mem_if.mem_rsp_valid), W'(0));
        check("rst_busy", W'(busy), W'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", W'(mem_if.mem_req_ready), W'(1));
        check("post_rst_busy", W'(busy), W'(0));
        @(posedge clk);
        #1;

        // table-driven vectors: reads checked for data, tag and latency
        for (int v = 0; v < NV; v++) begin
            send(vecs[v].rw, vecs[v].addr, vecs[v].byteen, vecs[v].data, vecs[v].tag, vecs[v].exp);
            if (!vecs[v].rw) begin
                wait_rsp("table_rsp", lat);
                check("table_latency", W'(lat), W'(LATENCY));
            end
        end

        // backpressure / full queue
        for (int a = 0; a < 4; a++) send(1'b1, ADDR_WIDTH'(8'h20 + a), '1, pat(8'(8'h20 + a)), '0, '0);
        mem_if.mem_rsp_ready = 1'b0;
        for (int t = 0; t < 4; t++) send(1'b0, ADDR_WIDTH'(8'h20 + t), '0, '0, TAG_WIDTH'(t), pat(8'(8'h20 + t)));
        mem_if.mem_req_valid = 1'b1;
        mem_if.mem_req_rw    = 1'b0;
        mem_if.mem_req_addr  = 8'h24;
        @(negedge clk);
        check("full_read_ready", W'(mem_if.mem_req_ready), W'(0));
        check("full_busy", W'(busy), W'(1));
        @(posedge clk);
        #1 mem_if.mem_req_valid = 1'b0;
        send(1'b1, 8'h20, '1, pat(8'h99), '0, '0);
        mem_if.mem_req_rw = 1'b0;
        @(negedge clk);
        check("still_full_ready", W'(mem_if.mem_req_ready), W'(0));
        @(posedge clk);
        #1 mem_if.mem_rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("drain_b2b_valid", W'(mem_if.mem_rsp_valid), W'(1));
            check_head("drain_rsp");
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        check("drain_busy", W'(busy), W'(0));
        @(posedge clk);
        #1;
        send(1'b0, 8'h20, '0, '0, 2'd1, pat(8'h99));
        wait_rsp("write_while_full_rsp", lat);

        // read then immediate write to the same line
        send(1'b1, 8'h50, '1, {16{8'h11}}, '0, '0);
        send(1'b0, 8'h50, '0, '0, 2'd1, {16{8'h11}});
        send(1'b1, 8'h50, '1, {16{8'h22}}, '0, '0);
        wait_rsp("rw_order_old", lat);
        send(1'b0, 8'h50, '0, '0, 2'd2, {16{8'h22}});
        wait_rsp("rw_order_new", lat);

        // 16 reads with random response backpressure (exercises wrap and push+pop at full-1)
        for (int a = 0; a < 16; a++) send(1'b1, ADDR_WIDTH'(8'h80 + a), '1, pat(8'(8'h80 + a)), '0, '0);
        fork
            begin
                for (int i = 0; i < 16; i++)
                    send(1'b0, ADDR_WIDTH'(8'h80 + i), '0, '0, TAG_WIDTH'(i), pat(8'(8'h80 + i)));
            end
            begin
                int got;
                got = 0;
                for (int c = 0; c < 2000 && got < 16; c++) begin
                    @(posedge clk);
                    #1 mem_if.mem_rsp_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (mem_if.mem_rsp_valid && mem_if.mem_rsp_ready) begin
                        check_head("rand_rsp");
                        got++;
                    end
                end
                check("rand_count", W'(got), W'(16));
            end
        join
        @(posedge clk);
        #1 mem_if.mem_rsp_ready = 1'b1;
        @(negedge clk);
        check("rand_busy", W'(busy), W'(0));
        check("rand_q_empty", W'(exp_q.size()), W'(0));
        @(posedge clk);
        #1;

        // async reset with 3 reads pending
        send(1'b1, 8'h60, '1, pat(8'h60), '0, '0);
        mem_if.mem_rsp_ready = 1'b0;
        for (int t = 0; t < 3; t++) send(1'b0, ADDR_WIDTH'(8'h60 + t), '0, '0, TAG_WIDTH'(t), '0);
        repeat (5) @(posedge clk);
        #2;
        check("pre_rst_valid", W'(mem_if.mem_rsp_valid), W'(1));
        #1 rst = 1'b1;
        #1;
        check("async_rst_valid", W'(mem_if.mem_rsp_valid), W'(0));
        check("async_rst_busy", W'(busy), W'(0));
        check("async_rst_ready", W'(mem_if.mem_req_ready), W'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mem_if.mem_rsp_ready = 1'b1;
        @(negedge clk);
        check("rel_ready", W'(mem_if.mem_req_ready), W'(1));
        check("rel_busy", W'(busy), W'(0));
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_if.mem_rsp_valid) stale++;
        end
        check("no_stale_rsp", W'(stale), W'(0));
        @(posedge clk);
        #1;
        send(1'b0, 8'h60, '0, '0, 2'd3, pat(8'h60));
        wait_rsp("ram_survives_rst", lat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
